// File: rtl/pong_pkg.sv
// pong_pkg: shared Pong state encodings, screen geometry and datapath widths
package pong_pkg;
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_e;
    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;
    localparam int BALL_SIZE     = 8;
    localparam int PADDLE_WIDTH  = 8;
    localparam int PADDLE_HEIGHT = 64;
    localparam int SPEED_W       = 3;
    localparam int SCORE_W       = 4;
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/pong_tick_timer.sv
// pong_tick_timer: loadable frame-tick down-counter; done_o flags the last tick
module pong_tick_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         tick_i,
    output logic         done_o
);
    logic [W-1:0] cnt_q, cnt_d;
    // load wins over counting; the counter parks at zero
    always_comb cnt_d = load_i ? load_val_i : (tick_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    // count register
    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
    assign done_o = (cnt_q == W'(1));
endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: Pong match sequencer (scores, serve, speed); PONG_SPEEDUP_EN enables hit-driven speedup
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE        = 7,
    parameter int SERVE_TICKS      = 60,
    parameter int POINT_TICKS      = 30,
    parameter int BASE_SPEED       = 2,
    parameter int MAX_SPEED        = 6,
    parameter int HITS_PER_SPEEDUP = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       start,
    input  logic       hit,
    input  logic       miss_l,
    input  logic       miss_r,
    output logic       move_en,
    output logic       ball_load,
    output logic       serve_dir_x,
    output logic [2:0] speed,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       game_over,
    output logic       winner,
    output logic [2:0] state
);
    localparam logic [2:0] S_IDLE  = ST_IDLE;
    localparam logic [2:0] S_SERVE = ST_SERVE;
    localparam logic [2:0] S_PLAY  = ST_PLAY;
    localparam logic [2:0] S_POINT = ST_POINT;
    localparam logic [2:0] S_OVER  = ST_OVER;
    localparam int TW = $clog2(max_int(SERVE_TICKS, POINT_TICKS) + 1);

    logic [2:0]         state_q, state_d;
    logic [SCORE_W-1:0] score_l_q, score_l_d, score_r_q, score_r_d;
    logic               dir_q, dir_d, winner_q, winner_d, load_q;
    logic               serve_entry, t_load, t_done;
    logic [TW-1:0]      t_val;

    pong_tick_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (t_load),
        .load_val_i (t_val),
        .tick_i     (tick && (state_q == S_SERVE || state_q == S_POINT)),
        .done_o     (t_done)
    );

    // match FSM: start, timer expiry and miss handling (miss_l has priority)
    always_comb begin
        state_d     = state_q;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        dir_d       = dir_q;
        winner_d    = winner_q;
        serve_entry = 1'b0;
        t_load      = 1'b0;
        t_val       = TW'(SERVE_TICKS);
        if ((state_q == S_IDLE || state_q == S_OVER) && start) begin
            score_l_d   = '0;
            score_r_d   = '0;
            dir_d       = 1'b1;
            t_load      = 1'b1;
            serve_entry = 1'b1;
            state_d     = S_SERVE;
        end else if (state_q == S_SERVE && tick && t_done) begin
            state_d = S_PLAY;
        end else if (state_q == S_PLAY && (miss_l || miss_r)) begin
            if (miss_l) begin
                score_r_d = score_r_q + 1'b1;
                dir_d     = 1'b0;
            end else begin
                score_l_d = score_l_q + 1'b1;
                dir_d     = 1'b1;
            end
            if ((miss_l ? score_r_d : score_l_d) == SCORE_W'(WIN_SCORE)) begin
                winner_d = miss_l;
                state_d  = S_OVER;
            end else begin
                t_load  = 1'b1;
                t_val   = TW'(POINT_TICKS);
                state_d = S_POINT;
            end
        end else if (state_q == S_POINT && tick && t_done) begin
            t_load      = 1'b1;
            serve_entry = 1'b1;
            state_d     = S_SERVE;
        end
    end

    // match state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            score_l_q <= '0;
            score_r_q <= '0;
            dir_q     <= 1'b1;
            winner_q  <= 1'b0;
            load_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            dir_q     <= dir_d;
            winner_q  <= winner_d;
            load_q    <= serve_entry;
        end
    end

`ifdef PONG_SPEEDUP_EN
    localparam int HW = $clog2(HITS_PER_SPEEDUP + 1);
    logic [HW-1:0]      hits_q, hits_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    // a full hit count bumps speed one cycle later; every serve restores base speed
    always_comb begin
        hits_d  = hits_q;
        speed_d = speed_q;
        if (hits_q == HW'(HITS_PER_SPEEDUP)) begin
            hits_d  = '0;
            speed_d = (speed_q < SPEED_W'(MAX_SPEED)) ? speed_q + 1'b1 : speed_q;
        end
        if (state_q == S_PLAY && hit) hits_d = hits_d + 1'b1;
        if (serve_entry) begin
            hits_d  = '0;
            speed_d = SPEED_W'(BASE_SPEED);
        end
    end
    // speed and hit-count registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hits_q  <= '0;
            speed_q <= SPEED_W'(BASE_SPEED);
        end else begin
            hits_q  <= hits_d;
            speed_q <= speed_d;
        end
    end
    assign speed = speed_q;
`else
    logic unused_speedup;
    assign unused_speedup = hit ^ (HITS_PER_SPEEDUP == 0) ^ (MAX_SPEED == 0);
    assign speed = SPEED_W'(BASE_SPEED);
`endif

    assign state       = state_q;
    assign move_en     = (state_q == S_PLAY);
    assign game_over   = (state_q == S_OVER);
    assign ball_load   = load_q;
    assign serve_dir_x = dir_q;
    assign score_l     = score_l_q;
    assign score_r     = score_r_q;
    assign winner      = winner_q;
endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Game sequencer for the Pong datapath. It owns the match state machine (idle, serve countdown, play, point pause, game over), gates ball/paddle motion, and commands ball recentering. It keeps both scores and selects serve direction and ball speed. It sits between the frame-tick generator and the ball/paddle movement logic, and consumes that logic's miss/hit event pulses.

## Interface
Parameters:
- WIN_SCORE, 7: points needed to win; legal range 1..15.
- SERVE_TICKS, 60: frame ticks spent in SERVE before play starts; minimum 1.
- POINT_TICKS, 30: frame ticks spent frozen after a point; minimum 1.
- BASE_SPEED, 2: ball speed after every serve.
- MAX_SPEED, 6: speed saturation limit; at most 7.
- HITS_PER_SPEEDUP, 4: paddle hits per speed step; only used with PONG_SPEEDUP_EN.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- tick  in  1  one-cycle frame strobe; advances timers
- start  in  1  level; start or restart a match
- hit  in  1  one-cycle pulse: ball struck a paddle
- miss_l  in  1  one-cycle pulse: ball passed the left edge
- miss_r  in  1  one-cycle pulse: ball passed the right edge
- move_en  out  1  ball/paddle motion enable
- ball_load  out  1  one-cycle pulse: recenter the ball
- serve_dir_x  out  1  1 = serve right, 0 = serve left
- speed  out  3  ball step per motion update
- score_l, score_r  out  4 each  player scores
- game_over  out  1  match finished
- winner  out  1  0 = left, 1 = right; valid while game_over=1
- state  out  3  IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4

## Operation
- **IDLE:** On start=1, clear both scores, set serve_dir_x=1, load timer with SERVE_TICKS, go to SERVE.
- **SERVE:**
  - ball_load is high in the first SERVE cycle only.
  - Each tick decrements the timer.
  - A tick while the timer equals 1 moves to PLAY, so SERVE spans exactly SERVE_TICKS ticks.
- **PLAY:**
  - move_en=1.
  - miss_l increments score_r and sets serve_dir_x=0. miss_r increments score_l and sets serve_dir_x=1.
  - If the incremented score equals WIN_SCORE, go to OVER. Otherwise load timer with POINT_TICKS and go to POINT.
- **POINT:** move_en=0. The timer counts ticks as in SERVE. On expiry, load SERVE_TICKS, go to SERVE, reset speed to BASE_SPEED and clear the hit count.
- **OVER:**
  - game_over=1; winner holds the side that reached WIN_SCORE.
  - start=1 behaves as in IDLE: scores cleared, next state SERVE.
- **Ignored inputs:**
  - start outside IDLE and OVER.
  - hit, miss_l and miss_r outside PLAY.
- **Simultaneous events:**
  - miss_l and miss_r in the same cycle: only miss_l is counted.
  - tick coincident with a miss in PLAY: the miss is processed and the tick has no effect.
- **Arithmetic:**
  - Scores never exceed WIN_SCORE, so there is no wrap.
  - Timer width is clog2(max(SERVE_TICKS, POINT_TICKS)+1).

## Timing
- All outputs are registered or decoded directly from registered state. No input reaches an output combinationally.
- **move_en:** high exactly in cycles where state==PLAY. It drops in the cycle after a qualifying miss.
- **ball_load:** high in the first cycle after entering SERVE, for one cycle.
- **Score latency:** a score updates in the cycle after its miss pulse; game_over also rises in that cycle when WIN_SCORE is reached.
- **Reset values:**
  - state=IDLE; move_en=0; ball_load=0.
  - serve_dir_x=1; speed=BASE_SPEED.
  - score_l=score_r=0; game_over=0; winner=0.
  - Timer and hit count are 0.
- **Reset mid-operation:** rst_n low at any clock edge forces all reset values at that edge, regardless of state or pending pulses.

## Configuration
- **PONG_SPEEDUP_EN defined:**
  - Each hit in PLAY increments a hit counter.
  - When the count reaches HITS_PER_SPEEDUP, speed increments (saturating at MAX_SPEED) on the next cycle and the count clears.
  - Speed returns to BASE_SPEED on every entry to SERVE.
- **PONG_SPEEDUP_EN undefined:**
  - speed is constant BASE_SPEED and hit is ignored.
  - No hit counter is built.

## Structure
- **Shared package pong_pkg:**
  - State enum with the encodings listed under Interface.
  - Screen constants: SCREEN_WIDTH=640, SCREEN_HEIGHT=480, BALL_SIZE, PADDLE_WIDTH, PADDLE_HEIGHT.
  - SPEED_W=3 and SCORE_W=4.
- **Sub-module pong_tick_timer:** loadable down-counter with tick enable and a done flag. It is used for both the SERVE and POINT timing.

## Test plan
Bench parameters: SERVE_TICKS=3, POINT_TICKS=2, WIN_SCORE=3, BASE_SPEED=2, MAX_SPEED=3, HITS_PER_SPEEDUP=2.
- Reset, then start pulse -> ball_load high exactly 1 cycle; state=SERVE; PLAY and move_en=1 after the 3rd tick, not earlier.
- In PLAY, miss_r -> next cycle score_l=1, serve_dir_x=1, move_en=0, state=POINT; after 2 ticks state=SERVE with a ball_load pulse.
- miss_l and miss_r in the same cycle -> score_r=1, score_l unchanged, serve_dir_x=0.
- Three miss_l across rallies -> score_r=3, game_over=1, winner=1; a later hit or miss pulse changes nothing; start -> scores 0, state=SERVE.
- With PONG_SPEEDUP_EN: 2 hits -> speed=3; 2 more hits -> speed stays 3; after the next point and serve -> speed=2. Without the macro, speed stays 2 throughout.
- rst_n low during POINT with score_l=2 -> at that edge state=IDLE, scores 0, move_en=0, speed=2.
